// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: access size encodings, FSM state type and default memory size for the load/store unit.
package dmem_lsu_pkg;
  localparam int DEF_MEM_BYTES = 256;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: CPU-side request/response bundle of the load/store unit.
interface dmem_lsu_if;
  logic        LSU_req_valid;
  logic        LSU_req_ready;
  logic        LSU_req_write;
  logic [1:0]  LSU_req_size;
  logic        LSU_req_unsigned;
  logic [31:0] LSU_req_addr;
  logic [31:0] LSU_req_wdata;
  logic        LSU_resp_valid;
  logic [31:0] LSU_resp_rdata;
  logic        LSU_resp_error;
  modport master (
    output LSU_req_valid, LSU_req_write, LSU_req_size, LSU_req_unsigned, LSU_req_addr, LSU_req_wdata,
    input  LSU_req_ready, LSU_resp_valid, LSU_resp_rdata, LSU_resp_error
  );
  modport slave (
    input  LSU_req_valid, LSU_req_write, LSU_req_size, LSU_req_unsigned, LSU_req_addr, LSU_req_wdata,
    output LSU_req_ready, LSU_resp_valid, LSU_resp_rdata, LSU_resp_error
  );
endinterface

// File: rtl/dmem_lsu_lane.sv
// dmem_lsu_lane: big-endian lane extract/extend for loads and lane merge for sub-word stores.
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ext,
  output logic [31:0] o_merge
);
  logic [4:0]  w_sh;
  logic [31:0] w_up, w_mask, w_ins;
  // Shifting left by the byte offset brings the addressed lane to the top.
  assign w_sh   = {i_off, 3'b000};
  assign w_up   = i_word << w_sh;
  assign o_ext  = i_size == SZ_B ? {{24{~i_uns & w_up[31]}}, w_up[31:24]} :
                  i_size == SZ_H ? {{16{~i_uns & w_up[31]}}, w_up[31:16]} : i_word;
  assign w_mask = i_size == SZ_B ? 32'hFF00_0000 >> w_sh :
                  i_size == SZ_H ? 32'hFFFF_0000 >> w_sh : 32'hFFFF_FFFF;
  assign w_ins  = i_size == SZ_B ? {i_wdata[7:0], 24'h0} >> w_sh :
                  i_size == SZ_H ? {i_wdata[15:0], 16'h0} >> w_sh : i_wdata;
  assign o_merge = (i_word & ~w_mask) | (w_ins & w_mask);
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit with range/alignment checks and read-modify-write sub-word stores.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_lsu_if.slave   lsu,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);
  state_e      r_state, w_next;
  size_e       r_size;
  logic [31:0] r_addr, r_data, r_rdata;
  logic        r_write, r_uns, r_err;
  logic        w_acc, w_err;
  logic [32:0] w_end;
  logic [31:0] w_ext, w_merge;
  assign w_acc = lsu.LSU_req_valid && r_state == IDLE;
  assign w_end = {1'b0, lsu.LSU_req_addr} + (lsu.LSU_req_size == SZ_B ? 33'd1 :
                                             lsu.LSU_req_size == SZ_H ? 33'd2 : 33'd4);
  assign w_err = lsu.LSU_req_size == SZ_X ||
                 (lsu.LSU_req_size == SZ_H && lsu.LSU_req_addr[0]) ||
                 (lsu.LSU_req_size == SZ_W && lsu.LSU_req_addr[1:0] != 2'b00) ||
                 w_end > 33'(MEM_BYTES);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_acc ? (w_err ? RESP :
                                         (lsu.LSU_req_write && lsu.LSU_req_size == SZ_W) ? WR : RD) : IDLE) :
             r_state == RD   ? (r_write ? WR : RESP) :
             r_state == WR   ? RESP : IDLE;
  end
  // r_data holds store data from accept, then the merged word after the RMW read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_size  <= SZ_B;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_addr  <= lsu.LSU_req_addr;
        r_data  <= lsu.LSU_req_wdata;
        r_size  <= size_e'(lsu.LSU_req_size);
        r_write <= lsu.LSU_req_write;
        r_uns   <= lsu.LSU_req_unsigned;
        r_err   <= w_err;
        if (w_err) r_rdata <= '0;
      end
      if (r_state == RD) begin
        if (r_write) r_data <= w_merge;
        else r_rdata <= w_ext;
      end
      if (r_state == WR) r_rdata <= '0;
    end
  end
  dmem_lsu_lane u_lane (
    .i_word  (DMEM_data_out),
    .i_off   (r_addr[1:0]),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .i_wdata (r_data),
    .o_ext   (w_ext),
    .o_merge (w_merge)
  );
  assign lsu.LSU_req_ready  = r_state == IDLE;
  assign lsu.LSU_resp_valid = r_state == RESP;
  assign lsu.LSU_resp_rdata = r_rdata;
  assign lsu.LSU_resp_error = r_state == RESP && r_err;
  assign DMEM_mem_read  = r_state == RD;
  assign DMEM_mem_write = r_state == WR;
  assign DMEM_address   = (r_state == RD || r_state == WR) ? {r_addr[31:2], 2'b00} : '0;
  assign DMEM_data_in   = r_state == WR ? r_data : '0;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed table, reset and back-to-back sequences, plus random traffic against a byte-array reference.
module tb_dmem_lsu;
  localparam int MB = 252;
  logic clk = 0, rst_n = 0;
  logic [31:0] DMEM_address, DMEM_data_in, dmem_out;
  logic DMEM_mem_write, DMEM_mem_read;
  logic [7:0] mem [MB];
  logic [7:0] ref_mem [MB];
  int checks = 0, failures = 0, strobe_cnt = 0;
  dmem_lsu_if bus();
  dmem_lsu #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n), .lsu(bus),
    .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(dmem_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mword(int a);
    return (a >= 0 && a + 3 < MB) ? {mem[a], mem[a+1], mem[a+2], mem[a+3]} : 32'h0;
  endfunction
  always_comb dmem_out = mword(int'(DMEM_address));
  always @(negedge clk) begin
    if (DMEM_mem_read || DMEM_mem_write) strobe_cnt++;
    if (DMEM_mem_write && int'(DMEM_address) + 3 < MB)
      {mem[DMEM_address], mem[DMEM_address+1], mem[DMEM_address+2], mem[DMEM_address+3]} = DMEM_data_in;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic void model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
    int n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    longint ea = longint'(a);
    logic [31:0] v = 0;
    er = sz == 3 || ea % n != 0 || ea + n > MB;
    rd = 0;
    lat = er ? 1 : (w && n < 4) ? 3 : 2;
    if (er) return;
    for (int i = 0; i < n; i++) begin
      if (w) ref_mem[ea+i] = 8'(d >> (8 * (n - 1 - i)));
      else v = (v << 8) | 32'(ref_mem[ea+i]);
    end
    if (!w) rd = (!u && n < 4 && v[8*n-1]) ? v | (32'hFFFF_FFFF << (8 * n)) : v;
  endfunction
  task automatic run(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat, output int strb);
    int s0;
    @(negedge clk);
    bus.LSU_req_write = w; bus.LSU_req_size = sz; bus.LSU_req_unsigned = u;
    bus.LSU_req_addr = a; bus.LSU_req_wdata = d; bus.LSU_req_valid = 1;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    bus.LSU_req_valid = 0;
    lat = 1;
    while (!bus.LSU_resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    rd = bus.LSU_resp_rdata; er = bus.LSU_resp_error;
    strb = strobe_cnt - s0;
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'(bus.LSU_resp_valid), 0);
  endtask
  typedef struct {
    logic w; logic [1:0] sz; logic u; logic [31:0] a, d, rd; logic er; int lat; logic mchk; logic [31:0] mexp;
  } vec_t;
  vec_t tv[16];
  initial begin
    logic [31:0] rd, mrd, saved;
    logic er, mer;
    int lat, mlat, strb, acc, rsp, rdy_low, bad;
    bus.LSU_req_valid = 0; bus.LSU_req_write = 0; bus.LSU_req_size = 0;
    bus.LSU_req_unsigned = 0; bus.LSU_req_addr = 0; bus.LSU_req_wdata = 0;
    for (int i = 0; i < MB; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    {mem[32], mem[33], mem[34], mem[35]} = 32'h80FF_7F01;
    for (int i = 32; i < 36; i++) ref_mem[i] = mem[i];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.LSU_req_ready), 1);
    chk("rst_outs", {bus.LSU_resp_valid, bus.LSU_resp_error, DMEM_mem_read, DMEM_mem_write}, 0);
    chk("rst_buses", bus.LSU_resp_rdata | DMEM_address | DMEM_data_in, 0);
    @(negedge clk) rst_n = 1;
    tv[0]  = '{1, 2, 0, 32'h10, 32'h1122_3344, 0, 0, 2, 1, 32'h1122_3344};
    tv[1]  = '{0, 2, 0, 32'h10, 0, 32'h1122_3344, 0, 2, 0, 0};
    tv[2]  = '{1, 0, 0, 32'h12, 32'h0000_00AA, 0, 0, 3, 1, 32'h1122_AA44};
    tv[3]  = '{1, 1, 0, 32'h10, 32'h0000_BEEF, 0, 0, 3, 1, 32'hBEEF_AA44};
    tv[4]  = '{0, 2, 0, 32'h10, 0, 32'hBEEF_AA44, 0, 2, 0, 0};
    tv[5]  = '{0, 0, 0, 32'h20, 0, 32'hFFFF_FF80, 0, 2, 0, 0};
    tv[6]  = '{0, 0, 1, 32'h20, 0, 32'h0000_0080, 0, 2, 0, 0};
    tv[7]  = '{0, 1, 0, 32'h22, 0, 32'h0000_7F01, 0, 2, 0, 0};
    tv[8]  = '{0, 1, 1, 32'h20, 0, 32'h0000_80FF, 0, 2, 0, 0};
    tv[9]  = '{0, 2, 0, 32'h13, 0, 0, 1, 1, 0, 0};
    tv[10] = '{0, 1, 0, 32'h21, 0, 0, 1, 1, 0, 0};
    tv[11] = '{0, 3, 0, 32'h10, 0, 0, 1, 1, 1, 32'hBEEF_AA44};
    tv[12] = '{0, 2, 0, 32'hFC, 0, 0, 1, 1, 0, 0};
    tv[13] = '{1, 0, 0, 32'hFC, 32'h77, 0, 1, 1, 0, 0};
    tv[14] = '{1, 0, 0, 32'hFB, 32'h1234_565A, 0, 0, 3, 0, 0};
    tv[15] = '{0, 0, 1, 32'hFB, 0, 32'h0000_005A, 0, 2, 0, 0};
    for (int i = 0; i < 16; i++) begin
      model(tv[i].w, tv[i].sz, tv[i].u, tv[i].a, tv[i].d, mrd, mer, mlat);
      run(tv[i].w, tv[i].sz, tv[i].u, tv[i].a, tv[i].d, rd, er, lat, strb);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d_error", i), 32'(er), 32'(tv[i].er));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_strobes", i), 32'(strb), tv[i].er ? 0 : 32'(tv[i].lat - 1));
      if (tv[i].mchk) chk($sformatf("v%0d_mem", i), mword(int'({tv[i].a[31:2], 2'b00})), tv[i].mexp);
    end
    {mem[48], mem[49], mem[50], mem[51]} = 32'h0102_0304;
    for (int i = 48; i < 52; i++) ref_mem[i] = mem[i];
    @(negedge clk);
    bus.LSU_req_write = 1; bus.LSU_req_size = 0; bus.LSU_req_addr = 32'h30;
    bus.LSU_req_wdata = 32'hFF; bus.LSU_req_valid = 1;
    @(posedge clk); #1 bus.LSU_req_valid = 0;
    @(posedge clk); #1;
    chk("rmw_in_wr", 32'(DMEM_mem_write), 1);
    rst_n = 0;
    #1;
    chk("rstwr_ready", 32'(bus.LSU_req_ready), 1);
    chk("rstwr_strobes", {DMEM_mem_read, DMEM_mem_write, bus.LSU_resp_valid, bus.LSU_resp_error}, 0);
    chk("rstwr_buses", DMEM_address | DMEM_data_in | bus.LSU_resp_rdata, 0);
    rsp = 0;
    @(negedge clk) rst_n = 1;
    repeat (4) begin @(negedge clk); if (bus.LSU_resp_valid) rsp++; end
    chk("rstwr_no_resp", 32'(rsp), 0);
    chk("rstwr_mem", mword(48), 32'h0102_0304);
    @(negedge clk);
    bus.LSU_req_write = 0; bus.LSU_req_size = 2; bus.LSU_req_addr = 32'h10; bus.LSU_req_valid = 1;
    acc = 0; rsp = 0; rdy_low = 0; strb = strobe_cnt;
    for (int i = 0; i < 12; i++) begin
      if (bus.LSU_req_ready) acc++; else rdy_low++;
      if (bus.LSU_resp_valid) begin rsp++; chk("b2b_rdata", bus.LSU_resp_rdata, 32'hBEEF_AA44); end
      @(negedge clk);
    end
    bus.LSU_req_valid = 0;
    chk("b2b_accepts", 32'(acc), 4);
    chk("b2b_resps", 32'(rsp), 4);
    chk("b2b_ready_low", 32'(rdy_low), 8);
    chk("b2b_reads", 32'(strobe_cnt - strb), 4);
    for (int i = 0; i < 300; i++) begin
      logic w, u;
      logic [1:0] sz;
      logic [31:0] a, d;
      w = 1'($urandom); u = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 255); d = $urandom;
      if ($urandom_range(0, 3) != 0) a = (sz == 1) ? a & ~32'h1 : (sz == 2) ? a & ~32'h3 : a;
      model(w, sz, u, a, d, mrd, mer, mlat);
      run(w, sz, u, a, d, rd, er, lat, strb);
      if (rd !== mrd || er !== mer || lat != mlat || strb != (mer ? 0 : mlat - 1)) begin
        failures++;
        $display("FAIL rand%0d w=%0d sz=%0d a=%h actual rd=%h er=%0d lat=%0d strb=%0d required rd=%h er=%0d lat=%0d",
                 i, w, sz, a, rd, er, lat, strb, mrd, mer, mlat);
      end
      checks++;
    end
    bad = 0;
    for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_bytes_differing", 32'(bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
